// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each transaction takes three cycles: grant (IDLE), memory access (ACCESS), acknowledge (RESP).
module dmem_arbiter #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_MEM_SIZE  = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_Req0,
  input  logic                      i_Req1,
  input  logic                      i_WrEn0,
  input  logic                      i_WrEn1,
  input  logic [MEM_ADDR_WIDTH-1:0] i_Addr0,
  input  logic [MEM_ADDR_WIDTH-1:0] i_Addr1,
  input  logic [DATA_WIDTH-1:0]     i_WData0,
  input  logic [DATA_WIDTH-1:0]     i_WData1,
  output logic                      o_Ack0,
  output logic                      o_Ack1,
  output logic [DATA_WIDTH-1:0]     o_RData,
  output logic                      o_Err,
  output logic [MEM_ADDR_WIDTH-1:0] o_MemAddr,
  output logic [DATA_WIDTH-1:0]     o_MemWData,
  output logic                      o_MemWrEn,
  input  logic [DATA_WIDTH-1:0]     i_MemRData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [MEM_ADDR_WIDTH:0] MEM_SIZE_W = (MEM_ADDR_WIDTH+1)'(DATA_MEM_SIZE);

  state_e                      state_q, state_d;
  logic                        r_last_q;
  logic                        win_q;
  logic                        wren_q;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic                        err_q;

  logic                        any_req;
  logic                        grant_d;
  logic                        in_range;

  assign any_req  = i_Req0 | i_Req1;
  assign in_range = ({1'b0, addr_q} < MEM_SIZE_W);

  // Tie goes to the port that did not win last; a lone request wins outright.
  always_comb begin
    grant_d = 1'b0;
    if (i_Req0 && i_Req1) begin
      grant_d = ~r_last_q;
    end else if (i_Req1) begin
      grant_d = 1'b1;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (!wren_q && in_range) begin
      rdata_d = i_MemRData;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; reset masks the write strobe and acks in an aborted cycle.
  always_comb begin
    o_MemWrEn  = 1'b0;
    o_Ack0     = 1'b0;
    o_Ack1     = 1'b0;
    o_Err      = 1'b0;
    o_MemAddr  = addr_q;
    o_MemWData = wdata_q;
    o_RData    = rdata_q;
    case (state_q)
      ACCESS: o_MemWrEn = wren_q & in_range & ~reset;
      RESP: begin
        o_Ack0 = ~win_q & ~reset;
        o_Ack1 = win_q & ~reset;
        o_Err  = err_q & ~reset;
      end
      default: ;
    endcase
  end

  // Transaction latch (IDLE->ACCESS) and response capture (ACCESS->RESP)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_q <= 1'b1;
      win_q    <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (state_q == IDLE && any_req) begin
      r_last_q <= grant_d;
      win_q    <= grant_d;
      wren_q   <= grant_d ? i_WrEn1  : i_WrEn0;
      addr_q   <= grant_d ? i_Addr1  : i_Addr0;
      wdata_q  <= grant_d ? i_WData1 : i_WData0;
    end else if (state_q == ACCESS) begin
      rdata_q  <= rdata_d;
      err_q    <= ~in_range;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1024-word behavioural memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_Req0, i_Req1, i_WrEn0, i_WrEn1;
  logic [31:0] i_Addr0, i_Addr1, i_WData0, i_WData1;
  logic        o_Ack0, o_Ack1, o_Err, o_MemWrEn;
  logic [31:0] o_RData, o_MemAddr, o_MemWData, i_MemRData;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.MEM_ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_MEM_SIZE(1024)) dut (
    .clk(clk), .reset(reset),
    .i_Req0(i_Req0), .i_Req1(i_Req1), .i_WrEn0(i_WrEn0), .i_WrEn1(i_WrEn1),
    .i_Addr0(i_Addr0), .i_Addr1(i_Addr1), .i_WData0(i_WData0), .i_WData1(i_WData1),
    .o_Ack0(o_Ack0), .o_Ack1(o_Ack1), .o_RData(o_RData), .o_Err(o_Err),
    .o_MemAddr(o_MemAddr), .o_MemWData(o_MemWData), .o_MemWrEn(o_MemWrEn),
    .i_MemRData(i_MemRData)
  );

  always #5 clk = ~clk;

  assign i_MemRData = (o_MemAddr < 32'd1024) ? mem[o_MemAddr[9:0]] : 32'd0;

  always @(posedge clk) begin
    if (o_MemWrEn && o_MemAddr < 32'd1024) mem[o_MemAddr[9:0]] <= o_MemWData;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic req, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      i_Req0 = req; i_WrEn0 = wr; i_Addr0 = addr; i_WData0 = wd;
    end else begin
      i_Req1 = req; i_WrEn1 = wr; i_Addr1 = addr; i_WData1 = wd;
    end
  endtask

  // Called just after an edge that leaves the DUT in IDLE; returns likewise.
  task automatic run_txn(input string tag, input int p, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
    logic inr;
    inr = (addr < 32'd1024);
    set_port(p, 1'b1, wr, addr, wd);
    @(negedge clk);
    check({tag, " idle wren"}, 32'(o_MemWrEn), 32'd0);
    step();
    @(negedge clk);
    check({tag, " acc wren"}, 32'(o_MemWrEn), 32'(wr && inr));
    check({tag, " acc addr"}, o_MemAddr, addr);
    check({tag, " acc acks"}, {30'd0, o_Ack1, o_Ack0}, 32'd0);
    step();
    @(negedge clk);
    check({tag, " resp ack0"}, 32'(o_Ack0), 32'(p == 0));
    check({tag, " resp ack1"}, 32'(o_Ack1), 32'(p == 1));
    check({tag, " resp err"}, 32'(o_Err), 32'(exp_err));
    check({tag, " resp rdata"}, o_RData, exp_rd);
    check({tag, " resp wren"}, 32'(o_MemWrEn), 32'd0);
    check({tag, " resp addr hold"}, o_MemAddr, addr);
    step();
    set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    @(negedge clk);
    check("rst ack0", 32'(o_Ack0), 32'd0);
    check("rst ack1", 32'(o_Ack1), 32'd0);
    check("rst err", 32'(o_Err), 32'd0);
    check("rst rdata", o_RData, 32'd0);
    check("rst memaddr", o_MemAddr, 32'd0);
    check("rst memwdata", o_MemWData, 32'd0);
    check("rst memwren", 32'(o_MemWrEn), 32'd0);
    step();
    reset = 1'b0;

    run_txn("wr0", 0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0);
    check("mem5", mem[5], 32'hDEADBEEF);
    run_txn("rd1", 1, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0);
    run_txn("wr1", 1, 1'b1, 32'd3, 32'hCAFEF00D, 32'd0, 1'b0);
    run_txn("rd0", 0, 1'b0, 32'd3, 32'd0, 32'hCAFEF00D, 1'b0);
    run_txn("oorw0", 0, 1'b1, 32'd1024, 32'h12345678, 32'd0, 1'b1);
    run_txn("oorr1", 1, 1'b0, 32'd2000, 32'd0, 32'd0, 1'b1);
    run_txn("lastw", 1, 1'b1, 32'd1023, 32'h0BADF00D, 32'd0, 1'b0);
    check("mem1023", mem[1023], 32'h0BADF00D);

    // Fresh reset, then both ports request continuously.
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_port(0, 1'b1, 1'b0, 32'd5, 32'd0);
    set_port(1, 1'b1, 1'b0, 32'd3, 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      check($sformatf("tie%0d addr", k), o_MemAddr, (k % 2 == 0) ? 32'd5 : 32'd3);
      check($sformatf("tie%0d acc acks", k), {30'd0, o_Ack1, o_Ack0}, 32'd0);
      step();
      @(negedge clk);
      check($sformatf("tie%0d acks", k), {30'd0, o_Ack1, o_Ack0},
            (k % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("tie%0d rdata", k), o_RData,
            (k % 2 == 0) ? 32'hDEADBEEF : 32'hCAFEF00D);
      step();
    end
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    step();

    // Port 1 wins alone; reset lands in its ACCESS cycle.
    set_port(1, 1'b1, 1'b1, 32'd9, 32'h55AA55AA);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("abort wren", 32'(o_MemWrEn), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("abort acks", {30'd0, o_Ack1, o_Ack0}, 32'd0);
    check("abort mem9", mem[9], 32'd0);
    set_port(0, 1'b1, 1'b0, 32'd5, 32'd0);
    step();
    @(negedge clk);
    check("post-rst tie addr", o_MemAddr, 32'd5);
    step();
    @(negedge clk);
    check("post-rst tie acks", {30'd0, o_Ack1, o_Ack0}, 32'd1);
    check("post-rst rdata", o_RData, 32'hDEADBEEF);
    step();
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    @(negedge clk);
    check("retry wren", 32'(o_MemWrEn), 32'd1);
    check("retry addr", o_MemAddr, 32'd9);
    step();
    @(negedge clk);
    check("retry acks", {30'd0, o_Ack1, o_Ack0}, 32'd2);
    check("retry mem9", mem[9], 32'h55AA55AA);
    step();
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 32, word-address width to data memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter DATA_MEM_SIZE, default 1024, number of valid memory words.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports i_Req0 / i_Req1  input  1  request from port 0 (core LSU) / port 1 (DMA/debug).
REQ-007 SHALL have ports i_WrEn0 / i_WrEn1  input  1  1 = write, 0 = read, per port.
REQ-008 SHALL have ports i_Addr0 / i_Addr1  input  MEM_ADDR_WIDTH  word address, per port.
REQ-009 SHALL have ports i_WData0 / i_WData1  input  DATA_WIDTH  write data, per port.
REQ-010 SHALL have ports o_Ack0 / o_Ack1  output  1  one-cycle completion pulse, per port.
REQ-011 SHALL have port o_RData  output  DATA_WIDTH  read data, valid only while an o_Ack is high.
REQ-012 SHALL have port o_Err  output  1  high with o_Ack when the address was out of range.
REQ-013 SHALL have ports o_MemAddr  output  MEM_ADDR_WIDTH, o_MemWData  output  DATA_WIDTH, o_MemWrEn  output  1  to the single-port data memory.
REQ-014 SHALL have port i_MemRData  input  DATA_WIDTH  combinational read data from memory.

Function
REQ-015 SHALL implement FSM with states IDLE, ACCESS, RESP; IDLE->ACCESS when any request is high, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-016 In IDLE with exactly one request high, SHALL grant that port.
REQ-017 In IDLE with both requests high, SHALL grant the port not equal to r_last (last granted port); r_last updates on every grant.
REQ-018 On the IDLE->ACCESS edge, SHALL latch winner id, WrEn, Addr, WData; later requester input changes SHALL be ignored until RESP ends.
REQ-019 During ACCESS, o_MemAddr/o_MemWData SHALL equal latched values; o_MemWrEn SHALL equal latched WrEn AND in-range AND NOT reset.
REQ-020 Outside ACCESS, o_MemWrEn SHALL be 0; o_MemAddr/o_MemWData SHALL hold last latched values.
REQ-021 Address in range iff latched Addr < DATA_MEM_SIZE; out-of-range write SHALL NOT assert o_MemWrEn.
REQ-022 On the ACCESS->RESP edge, SHALL register o_RData = i_MemRData for in-range reads, 0 for writes or out-of-range accesses.
REQ-023 During RESP, SHALL assert the winner's o_Ack for exactly one cycle; the other o_Ack SHALL be 0; o_Err = 1 iff out of range.
REQ-024 Latency: request sampled at edge N -> memory access in cycle N+1 -> o_Ack high in cycle N+2; one transaction per 3 cycles max.
REQ-025 Requesters SHALL hold Req/WrEn/Addr/WData stable until o_Ack and drop Req on the edge ending the o_Ack cycle; requests high during ACCESS/RESP SHALL be deferred, not lost.
REQ-026 A port whose Req is still high in IDLE after its o_Ack SHALL be treated as a new request.
REQ-027 With both ports continuously requesting, grants SHALL strictly alternate (no starvation).
REQ-028 o_Ack0 and o_Ack1 SHALL never be high in the same cycle.

Reset
REQ-029 On reset at a clock edge: state = IDLE, r_last = 1 (port 0 wins first tie), o_Ack0 = o_Ack1 = 0, o_Err = 0, o_RData = 0, o_MemAddr = 0, o_MemWData = 0, o_MemWrEn = 0.
REQ-030 Reset during ACCESS or RESP SHALL abort the transaction: no memory write in that cycle, no o_Ack issued; the requester re-requests.

Verification
REQ-031 After reset, i_Req0=1, i_WrEn0=1, i_Addr0=5, i_WData0=0xDEADBEEF -> o_MemWrEn=1, o_MemAddr=5 two cycles after reset release; o_Ack0=1, o_Err=0 the next cycle.
REQ-032 Then port 1 reads Addr 5 (memory model returns 0xDEADBEEF) -> o_Ack1=1, o_RData=0xDEADBEEF, o_Ack0=0, o_MemWrEn=0 throughout.
REQ-033 Both ports request from the first IDLE after reset and re-request immediately after each ack for 6 transactions -> grant order 0,1,0,1,0,1; o_Ack pulses 3 cycles apart.
REQ-034 Port 0 writes Addr 1024 (DATA_MEM_SIZE) -> o_MemWrEn stays 0, o_Ack0=1 with o_Err=1, o_RData=0.
REQ-035 Reset asserted in the ACCESS cycle of a port 1 write -> o_MemWrEn=0 that cycle, no o_Ack1; after release, r_last=1 and a tie grants port 0.
